// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : axil_reg_slave
// Description : AXI4-Lite register slave with NUM_REGS-1 byte-writable
//               registers and a read-only ID register at the top index.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_reg_slave #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
  input  logic                    s0_axi_awvalid,
  output logic                    s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
  input  logic                    s0_axi_wvalid,
  output logic                    s0_axi_wready,
  output logic [1:0]              s0_axi_bresp,
  output logic                    s0_axi_bvalid,
  input  logic                    s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
  input  logic                    s0_axi_arvalid,
  output logic                    s0_axi_arready,
  output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
  output logic [1:0]              s0_axi_rresp,
  output logic                    s0_axi_rvalid,
  input  logic                    s0_axi_rready
);

  localparam int         c_idx_w  = ADDR_WIDTH - 2;
  localparam int         c_strb_w = DATA_WIDTH / 8;
  localparam int         c_ro_idx = NUM_REGS - 1;
  localparam logic [1:0] c_okay   = 2'b00;
  localparam logic [1:0] c_slverr = 2'b10;

  localparam logic [0:0] c_w_idle = 1'b0;
  localparam logic [0:0] c_w_resp = 1'b1;
  localparam logic [0:0] c_r_idle = 1'b0;
  localparam logic [0:0] c_r_data = 1'b1;

  logic                  r_ready_en;
  logic [0:0]            r_wstate;
  logic [0:0]            r_rstate;
  logic                  r_aw_held;
  logic                  r_w_held;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [c_strb_w-1:0]   r_wstrb;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_regs [0:NUM_REGS-2];

  logic                  w_awready;
  logic                  w_wready;
  logic                  w_arready;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_ar_hs;
  logic                  w_commit;
  logic [c_idx_w-1:0]    w_widx;
  logic                  w_wr_ok;
  logic [c_idx_w-1:0]    w_ridx;
  logic                  w_rd_ok;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Readies stay low through reset and rise on the first edge after release.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) r_ready_en <= 1'b0;
    else                 r_ready_en <= 1'b1;
  end

  assign w_awready = r_ready_en && (r_wstate == c_w_idle) && !r_aw_held;
  assign w_wready  = r_ready_en && (r_wstate == c_w_idle) && !r_w_held;
  assign w_arready = r_ready_en && (r_rstate == c_r_idle);
  assign w_aw_hs   = w_awready && s0_axi_awvalid;
  assign w_w_hs    = w_wready && s0_axi_wvalid;
  assign w_ar_hs   = w_arready && s0_axi_arvalid;
  assign w_commit  = (r_wstate == c_w_idle) && r_aw_held && r_w_held;

  assign w_widx  = r_awaddr[ADDR_WIDTH-1:2];
  assign w_wr_ok = (r_awaddr[1:0] == 2'b00) && (int'(w_widx) < NUM_REGS)
                   && (int'(w_widx) != c_ro_idx);
  assign w_ridx  = s0_axi_araddr[ADDR_WIDTH-1:2];
  assign w_rd_ok = (s0_axi_araddr[1:0] == 2'b00) && (int'(w_ridx) < NUM_REGS);

  always_comb begin
    w_rd_data = '0;
    if (w_rd_ok) begin
      if (int'(w_ridx) == c_ro_idx) w_rd_data = ID_VALUE;
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (int'(w_ridx) == i) w_rd_data = r_regs[i];
      end
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS - 1; i++) r_regs[i] <= '0;
    end else if (w_commit && w_wr_ok) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        for (int b = 0; b < c_strb_w; b++) begin
          if ((int'(w_widx) == i) && r_wstrb[b]) r_regs[i][8*b +: 8] <= r_wdata[8*b +: 8];
        end
      end
    end
  end

  // Address and data are latched independently; commit happens one edge
  // after both are held, so they may arrive in either order.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      r_wstate  <= c_w_idle;
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_okay;
    end else if (r_wstate == c_w_idle) begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s0_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s0_axi_wdata;
        r_wstrb  <= s0_axi_wstrb;
      end
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? c_okay : c_slverr;
        r_wstate  <= c_w_resp;
      end
    end else if (s0_axi_bready) begin
      r_bvalid <= 1'b0;
      r_wstate <= c_w_idle;
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      r_rstate <= c_r_idle;
      r_rvalid <= 1'b0;
      r_rresp  <= c_okay;
      r_rdata  <= '0;
    end else if (r_rstate == c_r_idle) begin
      if (w_ar_hs) begin
        r_rdata  <= w_rd_data;
        r_rresp  <= w_rd_ok ? c_okay : c_slverr;
        r_rvalid <= 1'b1;
        r_rstate <= c_r_data;
      end
    end else if (s0_axi_rready) begin
      r_rvalid <= 1'b0;
      r_rstate <= c_r_idle;
    end
  end

  assign s0_axi_awready = w_awready;
  assign s0_axi_wready  = w_wready;
  assign s0_axi_arready = w_arready;
  assign s0_axi_bvalid  = r_bvalid;
  assign s0_axi_bresp   = r_bresp;
  assign s0_axi_rvalid  = r_rvalid;
  assign s0_axi_rresp   = r_rresp;
  assign s0_axi_rdata   = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_reg_slave
// Description : Self-checking bench for axil_reg_slave against an array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axil_reg_slave;
  localparam int          DW  = 32;
  localparam int          AW  = 8;
  localparam int          NR  = 8;
  localparam logic [31:0] IDV = 32'hA5A5_0001;

  logic          s0_axi_aclk;
  logic          s0_axi_aresetn;
  logic [AW-1:0] s0_axi_awaddr;
  logic          s0_axi_awvalid;
  logic          s0_axi_awready;
  logic [DW-1:0] s0_axi_wdata;
  logic [3:0]    s0_axi_wstrb;
  logic          s0_axi_wvalid;
  logic          s0_axi_wready;
  logic [1:0]    s0_axi_bresp;
  logic          s0_axi_bvalid;
  logic          s0_axi_bready;
  logic [AW-1:0] s0_axi_araddr;
  logic          s0_axi_arvalid;
  logic          s0_axi_arready;
  logic [DW-1:0] s0_axi_rdata;
  logic [1:0]    s0_axi_rresp;
  logic          s0_axi_rvalid;
  logic          s0_axi_rready;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [NR];
  logic [1:0]  resp_a;
  logic [31:0] rd_a;

  axil_reg_slave #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .ID_VALUE(IDV)) dut (
    .s0_axi_aclk(s0_axi_aclk), .s0_axi_aresetn(s0_axi_aresetn),
    .s0_axi_awaddr(s0_axi_awaddr), .s0_axi_awvalid(s0_axi_awvalid), .s0_axi_awready(s0_axi_awready),
    .s0_axi_wdata(s0_axi_wdata), .s0_axi_wstrb(s0_axi_wstrb), .s0_axi_wvalid(s0_axi_wvalid),
    .s0_axi_wready(s0_axi_wready), .s0_axi_bresp(s0_axi_bresp), .s0_axi_bvalid(s0_axi_bvalid),
    .s0_axi_bready(s0_axi_bready), .s0_axi_araddr(s0_axi_araddr), .s0_axi_arvalid(s0_axi_arvalid),
    .s0_axi_arready(s0_axi_arready), .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
    .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rready(s0_axi_rready)
  );

  initial s0_axi_aclk = 1'b0;
  always #5 s0_axi_aclk = ~s0_axi_aclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  // Reference model: word array plus address rules.
  function automatic bit addr_ok(input logic [7:0] a);
    return (a[1:0] == 2'b00) && (int'(a >> 2) < NR);
  endfunction
  function automatic logic [1:0] exp_bresp(input logic [7:0] a);
    return (addr_ok(a) && int'(a >> 2) != NR - 1) ? 2'b00 : 2'b10;
  endfunction
  function automatic logic [1:0] exp_rresp(input logic [7:0] a);
    return addr_ok(a) ? 2'b00 : 2'b10;
  endfunction
  function automatic logic [31:0] exp_rdata(input logic [7:0] a);
    if (!addr_ok(a)) return 32'h0;
    if (int'(a >> 2) == NR - 1) return IDV;
    return mem[int'(a >> 2)];
  endfunction
  function automatic void model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (exp_bresp(a) == 2'b00)
      for (int b = 0; b < 4; b++) if (s[b]) mem[int'(a >> 2)][8*b +: 8] = d[8*b +: 8];
  endfunction
  function automatic void model_clear();
    for (int i = 0; i < NR; i++) mem[i] = 32'h0;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int hold, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    resp = 2'bxx;
    while (!(aw_done && w_done)) begin
      if (cyc > 20) begin
        checks++; errors++;
        $display("FAIL write_capture addr=%h got no handshake within 20 cycles", a);
        s0_axi_awvalid = 0; s0_axi_wvalid = 0;
        return;
      end
      s0_axi_awaddr = a; s0_axi_wdata = d; s0_axi_wstrb = s;
      s0_axi_awvalid = !aw_done && (cyc >= aw_dly);
      s0_axi_wvalid  = !w_done && (cyc >= w_dly);
      aw_hs = s0_axi_awvalid && s0_axi_awready;
      w_hs  = s0_axi_wvalid && s0_axi_wready;
      @(posedge s0_axi_aclk); #1;
      aw_done |= aw_hs; w_done |= w_hs; cyc++;
    end
    s0_axi_awvalid = 0; s0_axi_wvalid = 0;
    checks++;
    if (s0_axi_bvalid !== 1'b0) begin
      errors++; $display("FAIL bvalid_early addr=%h got %b want 0", a, s0_axi_bvalid);
    end
    @(posedge s0_axi_aclk); #1;
    checks++;
    if (s0_axi_bvalid !== 1'b1 || s0_axi_bresp !== exp_bresp(a)) begin
      errors++;
      $display("FAIL bresp addr=%h got bvalid=%b bresp=%b want 1/%b", a, s0_axi_bvalid, s0_axi_bresp, exp_bresp(a));
    end
    resp = s0_axi_bresp;
    model_write(a, d, s);
    for (int i = 0; i < hold; i++) begin
      @(posedge s0_axi_aclk); #1;
      checks++;
      if (s0_axi_bvalid !== 1'b1 || s0_axi_bresp !== exp_bresp(a) || s0_axi_awready !== 1'b0 || s0_axi_wready !== 1'b0) begin
        errors++;
        $display("FAIL bresp_hold addr=%h cyc=%0d got bv=%b br=%b awr=%b wr=%b want 1/%b/0/0",
                 a, i, s0_axi_bvalid, s0_axi_bresp, s0_axi_awready, s0_axi_wready, exp_bresp(a));
      end
    end
    s0_axi_bready = 1;
    @(posedge s0_axi_aclk); #1;
    s0_axi_bready = 0;
    checks++;
    if (s0_axi_bvalid !== 1'b0 || s0_axi_awready !== 1'b1 || s0_axi_wready !== 1'b1) begin
      errors++;
      $display("FAIL b_release addr=%h got bv=%b awr=%b wr=%b want 0/1/1", a, s0_axi_bvalid, s0_axi_awready, s0_axi_wready);
    end
  endtask

  task automatic do_read(input logic [7:0] a, input int rhold, output logic [31:0] data);
    logic [31:0] ed = exp_rdata(a);
    logic [1:0]  er = exp_rresp(a);
    s0_axi_araddr = a; s0_axi_arvalid = 1;
    checks++;
    if (s0_axi_arready !== 1'b1) begin
      errors++; $display("FAIL arready addr=%h got %b want 1", a, s0_axi_arready);
    end
    @(posedge s0_axi_aclk); #1;
    s0_axi_arvalid = 0;
    checks++;
    if (s0_axi_rvalid !== 1'b1 || s0_axi_rdata !== ed || s0_axi_rresp !== er) begin
      errors++;
      $display("FAIL rdata addr=%h got rv=%b rdata=%h rresp=%b want 1/%h/%b", a, s0_axi_rvalid, s0_axi_rdata, s0_axi_rresp, ed, er);
    end
    data = s0_axi_rdata;
    for (int i = 0; i < rhold; i++) begin
      @(posedge s0_axi_aclk); #1;
      checks++;
      if (s0_axi_rvalid !== 1'b1 || s0_axi_rdata !== ed || s0_axi_rresp !== er || s0_axi_arready !== 1'b0) begin
        errors++;
        $display("FAIL rdata_hold addr=%h got rv=%b rdata=%h arr=%b want 1/%h/0", a, s0_axi_rvalid, s0_axi_rdata, s0_axi_arready, ed);
      end
    end
    s0_axi_rready = 1;
    @(posedge s0_axi_aclk); #1;
    s0_axi_rready = 0;
    checks++;
    if (s0_axi_rvalid !== 1'b0 || s0_axi_arready !== 1'b1) begin
      errors++; $display("FAIL r_release addr=%h got rv=%b arr=%b want 0/1", a, s0_axi_rvalid, s0_axi_arready);
    end
  endtask

  task automatic release_reset();
    @(posedge s0_axi_aclk); #1;
    s0_axi_aresetn = 1; #1;
    checks++;
    if ({s0_axi_awready, s0_axi_wready, s0_axi_arready} !== 3'b000) begin
      errors++; $display("FAIL ready_pre_edge got %b want 000", {s0_axi_awready, s0_axi_wready, s0_axi_arready});
    end
    @(posedge s0_axi_aclk); #1;
    checks++;
    if ({s0_axi_awready, s0_axi_wready, s0_axi_arready} !== 3'b111) begin
      errors++; $display("FAIL ready_post_edge got %b want 111", {s0_axi_awready, s0_axi_wready, s0_axi_arready});
    end
  endtask

  task automatic test_reset();
    s0_axi_aresetn = 0;
    s0_axi_awaddr = 0; s0_axi_awvalid = 0; s0_axi_wdata = 0; s0_axi_wstrb = 0; s0_axi_wvalid = 0;
    s0_axi_bready = 0; s0_axi_araddr = 0; s0_axi_arvalid = 0; s0_axi_rready = 0;
    model_clear();
    repeat (2) @(posedge s0_axi_aclk);
    #1;
    checks++;
    if ({s0_axi_awready, s0_axi_wready, s0_axi_arready, s0_axi_bvalid, s0_axi_rvalid} !== 5'b0 ||
        s0_axi_bresp !== 2'b00 || s0_axi_rresp !== 2'b00 || s0_axi_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs got rdys=%b bv=%b rv=%b br=%b rr=%b rd=%h want all 0",
               {s0_axi_awready, s0_axi_wready, s0_axi_arready}, s0_axi_bvalid, s0_axi_rvalid, s0_axi_bresp, s0_axi_rresp, s0_axi_rdata);
    end
    release_reset();
    do_read(8'h00, 0, rd_a);
  endtask

  task automatic test_directed();
    do_write(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, resp_a);
    checks++; if (resp_a !== 2'b00) begin errors++; $display("FAIL w04_resp got %b want 00", resp_a); end
    do_read(8'h04, 0, rd_a);
    checks++; if (rd_a !== 32'hDEADBEEF) begin errors++; $display("FAIL r04 got %h want deadbeef", rd_a); end
    do_write(8'h08, 32'hFFFFFFFF, 4'hF, 0, 0, 0, resp_a);
    do_write(8'h08, 32'h11223344, 4'h5, 2, 0, 1, resp_a);
    checks++; if (resp_a !== 2'b00) begin errors++; $display("FAIL w08_resp got %b want 00", resp_a); end
    do_read(8'h08, 1, rd_a);
    checks++; if (rd_a !== 32'hFF22FF44) begin errors++; $display("FAIL r08 got %h want ff22ff44", rd_a); end
    do_write(8'h1C, 32'h12345678, 4'hF, 1, 0, 0, resp_a);
    checks++; if (resp_a !== 2'b10) begin errors++; $display("FAIL w1c_resp got %b want 10", resp_a); end
    do_write(8'h21, 32'h87654321, 4'hF, 0, 1, 0, resp_a);
    checks++; if (resp_a !== 2'b10) begin errors++; $display("FAIL w21_resp got %b want 10", resp_a); end
    do_write(8'h00, 32'hCAFEF00D, 4'h0, 0, 0, 0, resp_a);
    checks++; if (resp_a !== 2'b00) begin errors++; $display("FAIL strb0_resp got %b want 00", resp_a); end
    do_read(8'h1C, 0, rd_a);
    checks++; if (rd_a !== 32'hA5A50001) begin errors++; $display("FAIL r1c got %h want a5a50001", rd_a); end
    do_read(8'h40, 0, rd_a);
    checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL r40 got %h want 0", rd_a); end
    do_read(8'h00, 0, rd_a);
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    fork
      do_write(8'h10, 32'h55AA55AA, 4'hF, 0, 0, 5, resp_a);
      begin
        repeat (3) @(posedge s0_axi_aclk);
        #1;
        do_read(8'h00, 0, d);
      end
    join
    do_read(8'h10, 0, rd_a);
  endtask

  task automatic test_collision();
    do_write(8'h0C, 32'h1, 4'hF, 0, 0, 0, resp_a);
    fork
      do_write(8'h0C, 32'h2, 4'hF, 0, 0, 0, resp_a);
      begin
        @(posedge s0_axi_aclk); #1;
        do_read(8'h0C, 0, rd_a);
      end
    join
    checks++; if (rd_a !== 32'h1) begin errors++; $display("FAIL collide_old got %h want 1", rd_a); end
    do_read(8'h0C, 0, rd_a);
    checks++; if (rd_a !== 32'h2) begin errors++; $display("FAIL collide_new got %h want 2", rd_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a, ra;
    int sel;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = 8'($urandom_range(0, NR - 1) << 2);
      else if (sel == 7) a = 8'(($urandom_range(0, NR - 1) << 2) | $urandom_range(1, 3));
      else               a = 8'($urandom_range(NR, 63) << 2);
      do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 2), resp_a);
      ra = (it % 4 == 3) ? 8'($urandom_range(0, 255)) : a;
      do_read(ra, $urandom_range(0, 2), rd_a);
    end
  endtask

  task automatic test_reset_mid();
    s0_axi_aresetn = 0; model_clear();
    release_reset();
    s0_axi_araddr = 8'h10; s0_axi_arvalid = 1;
    @(posedge s0_axi_aclk); #1;
    s0_axi_arvalid = 0;
    s0_axi_awaddr = 8'h10; s0_axi_awvalid = 1;
    @(posedge s0_axi_aclk); #1;
    s0_axi_awvalid = 0;
    checks++;
    if (s0_axi_rvalid !== 1'b1 || s0_axi_awready !== 1'b0) begin
      errors++; $display("FAIL mid_setup got rv=%b awr=%b want 1/0", s0_axi_rvalid, s0_axi_awready);
    end
    #2 s0_axi_aresetn = 0;
    #1;
    checks++;
    if (s0_axi_rvalid !== 1'b0 || s0_axi_bvalid !== 1'b0 || {s0_axi_awready, s0_axi_wready, s0_axi_arready} !== 3'b000) begin
      errors++;
      $display("FAIL async_reset got rv=%b bv=%b rdys=%b want 0/0/000", s0_axi_rvalid, s0_axi_bvalid,
               {s0_axi_awready, s0_axi_wready, s0_axi_arready});
    end
    model_clear();
    release_reset();
    s0_axi_wdata = 32'hFFFFFFFF; s0_axi_wstrb = 4'hF; s0_axi_wvalid = 1;
    @(posedge s0_axi_aclk); #1;
    s0_axi_wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge s0_axi_aclk); #1;
      checks++;
      if (s0_axi_bvalid !== 1'b0) begin errors++; $display("FAIL stale_aw cyc=%0d got bvalid=%b want 0", i, s0_axi_bvalid); end
    end
    s0_axi_awaddr = 8'h14; s0_axi_awvalid = 1;
    @(posedge s0_axi_aclk); #1;
    s0_axi_awvalid = 0;
    @(posedge s0_axi_aclk); #1;
    checks++;
    if (s0_axi_bvalid !== 1'b1 || s0_axi_bresp !== 2'b00) begin
      errors++; $display("FAIL w_first got bv=%b br=%b want 1/00", s0_axi_bvalid, s0_axi_bresp);
    end
    model_write(8'h14, 32'hFFFFFFFF, 4'hF);
    s0_axi_bready = 1;
    @(posedge s0_axi_aclk); #1;
    s0_axi_bready = 0;
    do_read(8'h10, 0, rd_a);
    checks++; if (rd_a !== 32'h0) begin errors++; $display("FAIL r10_after_reset got %h want 0", rd_a); end
    do_read(8'h14, 0, rd_a);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/axil_reg_slave.md
AXIL_REG_SLAVE -- requirements
Module: axil_reg_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, byte address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, number of 32-bit registers; register NUM_REGS-1 is read-only.
REQ-004 SHALL have parameter ID_VALUE, default 32'hA5A5_0001, constant returned by register NUM_REGS-1.
REQ-005 Port s0_axi_aclk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port s0_axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-007 Ports s0_axi_awaddr in ADDR_WIDTH, s0_axi_awvalid in 1, s0_axi_awready out 1  write address channel.
REQ-008 Ports s0_axi_wdata in DATA_WIDTH, s0_axi_wstrb in DATA_WIDTH/8, s0_axi_wvalid in 1, s0_axi_wready out 1  write data channel.
REQ-009 Ports s0_axi_bresp out 2, s0_axi_bvalid out 1, s0_axi_bready in 1  write response channel.
REQ-010 Ports s0_axi_araddr in ADDR_WIDTH, s0_axi_arvalid in 1, s0_axi_arready out 1  read address channel.
REQ-011 Ports s0_axi_rdata out DATA_WIDTH, s0_axi_rresp out 2, s0_axi_rvalid out 1, s0_axi_rready in 1  read data channel.

Function
REQ-012 SHALL act as the AXI4-Lite slave behind the bus master port; every channel transfers only on valid AND ready high at a rising edge.
REQ-013 SHALL decode address as OKAY-valid when addr[1:0]==0 and addr[ADDR_WIDTH-1:2] < NUM_REGS; otherwise target is invalid.
REQ-014 Write FSM states: W_IDLE, W_RESP. Write and read FSMs SHALL be fully independent.
REQ-015 In W_IDLE, awready SHALL be high while no address is held and wready high while no data is held; AW and W are captured independently, in either order or same cycle.
REQ-016 The cycle after both AW and W are held, SHALL commit the write, drive bvalid=1, clear both held flags, enter W_RESP; awready=wready=0 while in W_RESP.
REQ-017 Write commit SHALL update only byte lanes whose wstrb bit is 1; wstrb==0 is a legal no-op returning OKAY.
REQ-018 bresp SHALL be 2'b00 for valid writable targets; 2'b10 (SLVERR) for invalid address or register NUM_REGS-1, with no register change.
REQ-019 In W_RESP, bvalid and bresp SHALL hold stable until bready; on handshake bvalid=0 and return to W_IDLE with readies high next cycle.
REQ-020 Read FSM states: R_IDLE, R_DATA. In R_IDLE arready=1; on AR handshake SHALL load rdata/rresp and set rvalid=1 on the same edge, enter R_DATA (one-cycle latency).
REQ-021 rdata SHALL be the register value before any write committing on that same edge (read-before-write on collision).
REQ-022 Read of register NUM_REGS-1 SHALL return ID_VALUE with OKAY; invalid address returns rdata=0, rresp=2'b10.
REQ-023 In R_DATA arready=0 and rdata/rresp/rvalid SHALL hold stable until rready; on handshake rvalid=0, return to R_IDLE.
REQ-024 Back-pressure: a held bvalid SHALL not block reads, and a held rvalid SHALL not block writes.

Reset
REQ-025 While s0_axi_aresetn=0, asynchronously: all registers 0, both FSMs idle, held flags cleared, awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rdata=0.
REQ-026 First rising edge after deassertion SHALL raise awready, wready, arready to 1.
REQ-027 Reset mid-transaction SHALL abandon it: no partial write commits, pending bvalid/rvalid drop immediately.

Verification
REQ-028 AW addr 0x04 and W data 0xDEADBEEF strb 0xF same cycle, bready=1 -> bvalid one cycle after capture, bresp=00; read 0x04 -> rdata 0xDEADBEEF, rresp=00, rvalid one cycle after AR.
REQ-029 W (0x11223344, strb 0x5) two cycles before AW 0x08, register holding 0xFFFFFFFF -> bresp=00; read 0x08 -> 0xFF22FF44.
REQ-030 Write 0x1C (reg 7) and write 0x21 -> both bresp=10, no register changes; read 0x1C -> 0xA5A50001 rresp=00; read 0x40 -> rdata 0, rresp=10.
REQ-031 Hold bready=0 for 5 cycles after write, issue read 0x00 meanwhile -> bvalid/bresp stable 5 cycles, awready=wready=0, read completes with rvalid one cycle after AR.
REQ-032 AR 0x0C and write commit to 0x0C on same edge (old 0x1, new 0x2) -> rdata 0x1; subsequent read -> 0x2.
REQ-033 Assert reset with AW held and rvalid=1 pending -> rvalid=0 immediately, target register unchanged (0), readies high one edge after release.
